// File: rtl/multi_breath_led.sv
// Multi-channel PWM LED driver: per-channel off / on / breath / blink sharing one PWM period counter.
// Define BREATH_PHASE_STAGGER_EN to spread the breath start duty of each channel across the ramp.
module multi_breath_led #(
  parameter int CH_NUM     = 4,
  parameter int CNT_W      = 16,
  parameter int PERIOD     = 50_000,
  parameter int STEP       = 25,
  parameter int BLINK_DIV  = 500,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [2*CH_NUM-1:0]   mode,
  output logic [CH_NUM-1:0]     led,
  output logic                  period_tick
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_ON     = 2'b01,
    MODE_BREATH = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

`ifdef BREATH_PHASE_STAGGER_EN
  localparam bit STAGGER_EN = 1'b1;
`else
  localparam bit STAGGER_EN = 1'b0;
`endif

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Breath start duty, used both at reset and on entry into breath mode.
  function automatic logic [CNT_W-1:0] start_value(input int ch);
    if (STAGGER_EN) return CNT_W'(((PERIOD / STEP) * ch / CH_NUM) * STEP);
    else            return '0;
  endfunction

  logic [CNT_W-1:0]   period_cnt;
  logic               period_end;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [CNT_W-1:0]   duty [CH_NUM];
  logic [CH_NUM-1:0]  dir;
  logic [2*CH_NUM-1:0] mode_q;
  logic [CH_NUM-1:0]  lit;

  assign period_end = (period_cnt == CNT_W'(PERIOD - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      period_cnt  <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= period_end;
      if (period_end) begin
        period_cnt <= '0;
        if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end else begin
        period_cnt <= period_cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: duty is a small register array, not a memory, so resetting every entry is intended.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q <= '0;
      dir    <= '0;
      for (int i = 0; i < CH_NUM; i++) duty[i] <= start_value(i);
    end else begin
      mode_q <= mode;
      for (int i = 0; i < CH_NUM; i++) begin
        if (mode_e'(mode[2*i +: 2]) == MODE_BREATH) begin
          // Entry restart wins over a coincident end-of-period step.
          if (mode_e'(mode_q[2*i +: 2]) != MODE_BREATH) begin
            duty[i] <= start_value(i);
            dir[i]  <= 1'b0;
          end else if (period_end) begin
            if (!dir[i]) begin
              if (duty[i] == CNT_W'(PERIOD)) dir[i]  <= 1'b1;
              else                           duty[i] <= duty[i] + CNT_W'(STEP);
            end else begin
              if (duty[i] == '0) dir[i]  <= 1'b0;
              else               duty[i] <= duty[i] - CNT_W'(STEP);
            end
          end
        end
      end
    end
  end

  // NOTE: lit gets a default before the loop so no latch is inferred.
  always_comb begin
    lit = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      case (mode_e'(mode[2*i +: 2]))
        MODE_OFF:    lit[i] = 1'b0;
        MODE_ON:     lit[i] = 1'b1;
        MODE_BREATH: lit[i] = (period_cnt < duty[i]);
        MODE_BLINK:  lit[i] = blink_phase;
        default:     lit[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) led <= {CH_NUM{ACTIVE_LOW}};
    else            led <= lit ^ {CH_NUM{ACTIVE_LOW}};
  end

endmodule

// File: tb/tb_multi_breath_led.sv
// Directed bench for multi_breath_led with a small period (10 cycles) so lit-cycle counts are hand-computable.
// Define BREATH_PHASE_STAGGER_EN for both bench and RTL to exercise the staggered start duty.
module tb_multi_breath_led;

  localparam int CH_NUM    = 2;
  localparam int CNT_W     = 8;
  localparam int PERIOD    = 10;
  localparam int STEP      = 5;
  localparam int BLINK_DIV = 2;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n;
  logic [2*CH_NUM-1:0]  mode;
  logic [CH_NUM-1:0]    led;
  logic                 period_tick;

  int checks = 0;
  int errors = 0;

  multi_breath_led #(
    .CH_NUM     (CH_NUM),
    .CNT_W      (CNT_W),
    .PERIOD     (PERIOD),
    .STEP       (STEP),
    .BLINK_DIV  (BLINK_DIV),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .mode        (mode),
    .led         (led),
    .period_tick (period_tick)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply mode for one cycle, then sample the pins just after the edge.
  task automatic step(input logic [3:0] m, output logic [1:0] lit_pins);
    mode = m;
    @(posedge sys_clk);
    #1;
    lit_pins = ~led;
  endtask

  task automatic run_period(input logic [3:0] m, output int n0, output int n1);
    logic [1:0] l;
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < PERIOD; c++) begin
      step(m, l);
      n0 += int'(l[0]);
      n1 += int'(l[1]);
    end
  endtask

  // Asserts reset away from the clock edge and releases it just after an edge.
  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    check("rst_led_now", led, 2'b11);
    check("rst_tick_now", period_tick, 1'b0);
    mode = '0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    check("rst_led_hold", led, 2'b11);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] l;
    int n0, n1;
    int breath_exp [8] = '{0, 5, 10, 10, 5, 0, 0, 5};
    int blink_exp  [6] = '{0, 0, 10, 10, 0, 0};
    int stagger_ch1 [2];
`ifdef BREATH_PHASE_STAGGER_EN
    stagger_ch1 = '{5, 10};
`else
    stagger_ch1 = '{0, 5};
`endif

    sys_rst_n = 1'b1;
    mode      = '0;
    #2;

    // Reset and idle: pins dark, tick every PERIOD cycles starting 10 cycles after release.
    do_reset();
    for (int n = 1; n <= 25; n++) begin
      step(4'b0000, l);
      if (n <= 3 || n % 10 == 0) check("idle_led", led, 2'b11);
      check("idle_tick", period_tick, (n % 10 == 0) ? 1'b1 : 1'b0);
    end

    // Breath on ch0, ch1 off.
    do_reset();
    for (int p = 0; p < 8; p++) begin
      run_period(4'b0010, n0, n1);
      check("breath_ch0", n0, breath_exp[p]);
      if (p == 0 || p == 7) check("breath_ch1_dark", n1, 0);
    end

    // On/off on ch1 mid-period: pin follows one cycle later.
    for (int c = 0; c < 3; c++) step(4'b0010, l);
    mode = 4'b0110;
    #1;
    check("on_before_edge", led[1], 1'b1);
    step(4'b0110, l);
    check("on_after_edge", led[1], 1'b0);
    step(4'b0110, l);
    check("on_hold", led[1], 1'b0);
    mode = 4'b0010;
    #1;
    check("off_before_edge", led[1], 1'b0);
    step(4'b0010, l);
    check("off_after_edge", led[1], 1'b1);

    // Blink on ch1: 20 dark, 20 lit.
    do_reset();
    for (int p = 0; p < 6; p++) begin
      run_period(4'b1100, n0, n1);
      check("blink_ch1", n1, blink_exp[p]);
      if (p == 2) check("blink_ch0_off", n0, 0);
    end

    // Re-entry on ch0 coinciding with period end restarts the ramp from 0.
    do_reset();
    for (int p = 0; p < 3; p++) run_period(4'b0010, n0, n1);
    check("reentry_pre_duty", n0, 10);
    n0 = 0;
    for (int c = 0; c < PERIOD; c++) begin
      step((c >= 6 && c <= 8) ? 4'b0001 : 4'b0010, l);
      n0 += int'(l[0]);
    end
    check("reentry_period", n0, 10);
    run_period(4'b0010, n0, n1);
    check("reentry_first", n0, 0);
    run_period(4'b0010, n0, n1);
    check("reentry_second", n0, 5);

    // Both channels breathing from reset; ch1 start depends on stagger build.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      run_period(4'b1010, n0, n1);
      check("both_ch0", n0, (p == 0) ? 0 : 5);
      check("both_ch1", n1, stagger_ch1[p]);
    end

    // Mid-operation reset forces pins dark at once.
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
